// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract built from one 4-bit adder slice reused once per clock, LSB nibble first.
// A start accepted at edge k gives done after edge k+NIBBLES; start is ignored while busy.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic                   carry_in,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_carry_out;
  logic            r_ovf;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [4:0]      w_slice;
  logic            w_last;

  assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4];
  assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
  assign w_last  = (r_cnt == CW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so the inversion and forced carry happen at capture.
            r_a         <= a;
            r_b         <= op_sub ? ~b : b;
            r_carry     <= op_sub | carry_in;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_state     <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sum[{r_cnt, 2'b00} +: 4] <= w_slice[3:0];
          r_carry                    <= w_slice[4];
          if (w_last) begin
            r_carry_out <= w_slice[4];
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_slice[3] != r_a[W-1]);
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with NIBBLES=4: vector table plus
// back-to-back and mid-run reset sequences.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic        carry_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .carry_in  (carry_in),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sub;
    logic        cin;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] exp_sum;
    logic        exp_co;
    logic        exp_ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation: pulse start, then expect 4 busy cycles and done on the 5th sample.
  task automatic run_vec(input vec_t v);
    int busy_cnt;
    bit got;
    logic [15:0] held_sum;
    @(negedge clk);
    start = 1'b1; op_sub = v.sub; carry_in = v.cin; a = v.va; b = v.vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    op_sub = 1'($urandom);
    carry_in = 1'($urandom);
    @(negedge clk);
    chk({v.name, " cleared_on_accept"}, {sum, carry_out, overflow, busy}, {16'h0, 1'b0, 1'b0, 1'b1});
    busy_cnt = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    chk({v.name, " done_seen"}, 32'(got), 32'd1);
    chk({v.name, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({v.name, " sum"}, 32'(sum), 32'(v.exp_sum));
    chk({v.name, " co_ov"}, {30'd0, carry_out, overflow}, {30'd0, v.exp_co, v.exp_ov});
    held_sum = v.exp_sum;
    @(negedge clk);
    chk({v.name, " hold"}, {done, busy, sum, carry_out, overflow},
        {1'b0, 1'b0, held_sum, v.exp_co, v.exp_ov});
  endtask

  vec_t vecs[8];

  initial begin
    int t1, t2, cyc;
    bit saw_done;
    vec_t rv;

    vecs[0] = '{"add_basic", 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"sub_borrow", 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{"add_ovf", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{"sub_ovf", 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{"add_cin", 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{"sub_zero", 1'b1, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{"add_negovf", 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; carry_in = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, sum, carry_out, overflow}, 20'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 2'b00);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // start held high: RUN ignores it, DONE accepts it, results 5 cycles apart.
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; carry_in = 1'b0; a = 16'h1111; b = 16'h2222;
    t1 = -1; t2 = -1; cyc = 0;
    for (int i = 0; i < 20 && t2 < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (done && t1 < 0) begin
        t1 = cyc;
        chk("b2b_first_sum", 32'(sum), 32'h3333);
        a = 16'h0F0F; b = 16'h0101;
      end else if (done) begin
        t2 = cyc;
        start = 1'b0;
        chk("b2b_second_sum", 32'(sum), 32'h1010);
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
        op_sub = 1'($urandom);
        carry_in = 1'($urandom);
      end
      if (t1 < 0 || t2 < 0) begin
        if (!done) op_sub = 1'($urandom);
        if (done) begin op_sub = 1'b0; carry_in = 1'b0; end
      end
    end
    start = 1'b0; op_sub = 1'b0; carry_in = 1'b0;
    chk("b2b_both_done", {31'd0, (t1 > 0) && (t2 > 0)}, 32'd1);
    chk("b2b_spacing", 32'(t2 - t1), 32'd5);
    chk("b2b_first_latency", 32'(t1), 32'd5);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN with cnt=2.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("partial_sum_cnt2", {busy, sum}, {1'b1, 16'h0055});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, sum, carry_out, overflow}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("no_done_after_reset", 32'(saw_done), 32'd0);
    rv = '{"post_reset", 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    run_vec(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs wide add/subtract by time-multiplexing a single internal 4-bit ripple adder slice, one nibble per clock, LSB nibble first. The inter-nibble carry is registered between cycles. It sits between a requester issuing start/operand commands and wide-arithmetic consumers. It trades NIBBLES cycles of latency for minimal adder area.

Parameters:
NIBBLES, 4, operand width in nibbles; data width W = 4*NIBBLES; legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when not busy
op_sub  input  1  0 = a+b+carry_in; 1 = a-b (b inverted, carry_in forced to 1)
carry_in  input  1  carry into nibble 0 when op_sub=0
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result valid
sum  output  W  result, held until the next accepted start
carry_out  output  1  carry out of MSB nibble (for sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow of the result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; operand registers, nibble counter and carry register cleared. Reset takes effect mid-operation; the in-flight result is discarded and no done is issued.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle, busy=0.
- Accept: start=1 on a rising edge while in IDLE or DONE.
  - Capture a into a_reg and b (or ~b if op_sub) into b_reg.
  - Capture the carry register: carry_in, or 1 if op_sub.
  - Latch op_sub; set cnt=0; clear sum; go to RUN.
  - start in RUN is ignored with no side effects.
  - The input ports may change freely after the accept edge.
- RUN, each cycle:
  - Slice inputs are a_reg[4cnt+3:4cnt], b_reg[4cnt+3:4cnt] and the carry register.
  - On the edge, write the slice sum into sum[4cnt+3:4cnt] and the slice carry into the carry register; cnt increments.
  - When cnt==NIBBLES-1 on the edge, go to DONE instead.
  - On that same edge, carry_out takes the slice carry.
  - On that same edge, overflow = (a_reg[W-1]==b_reg[W-1]) && (new sum[W-1]!=a_reg[W-1]). b_reg is the post-inversion operand.
- Latency: a start accepted at edge k gives busy=1 after edges k..k+NIBBLES-1 and done=1 after edge k+NIBBLES.
  - With NIBBLES=4, done is observed 4 cycles after the accept edge.
- DONE: returns to IDLE next edge unless start=1, in which case a new operation is accepted. Back-to-back throughput is one result per NIBBLES+1 cycles.
- carry_out and overflow hold from the DONE transition until the next accepted start, which clears them.
- Partial sum is visible on sum during RUN; consumers qualify sum with done.
- cnt width is clog2(NIBBLES); no other wrap-around behaviour.

Test Plan:
- NIBBLES=4, op_sub=0, cin=0, a=0x1234, b=0x4321, start 1 cycle -> busy 4 cycles; done pulse at edge 4 after accept; sum=0x5555, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all nibbles; sum=0x0000, carry_out=1, overflow=0.
- op_sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, carry_out=0 (borrow), overflow=0.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, overflow=1, carry_out=0. Then sub a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1, carry_out=1.
- start held high for the whole run with changing a/b -> only the first operands are used. A second start asserted in the DONE cycle is accepted; results appear 5 cycles apart.
- Deassert rst_n asynchronously mid-RUN (cnt=2) -> all outputs 0 immediately, no done. After release, a fresh start gives a correct result (0x00FF+0x0001=0x0100).
